fifo_word_packer: RTL and testbench

FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

---
 rtl/fifo_word_packer.sv | 115 +++++++++++
 tb/tb_fifo_word_packer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer.sv
// Packs DATA_W-wide bytes read from an upstream FIFO into LANES-wide output words,
// with flush support for partial words and a running count of emitted words.
module fifo_word_packer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANES  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fifo_empty,
    input  logic [DATA_W-1:0]       fifo_rdata,
    output logic                    fifo_rd_en,
    input  logic                    flush,
    output logic [DATA_W*LANES-1:0] out_data,
    output logic [LANES-1:0]        out_keep,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             word_cnt
);
    localparam int unsigned CNT_W = $clog2(LANES + 1);
    localparam logic [CNT_W:0]   LANES_C  = (CNT_W + 1)'(LANES);
    localparam logic [CNT_W-1:0] LANES_M1 = CNT_W'(LANES - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] fill_cnt;
    logic [CNT_W:0]   inflight;
    logic             pend, flush_pend, armed;
    logic             complete, flush_take, flush_done, handshake;
    logic [LANES-1:0] flush_keep;

    assign inflight   = {1'b0, fill_cnt} + (CNT_W + 1)'(pend);
    // The capture that fills the last lane goes straight to HOLD on the same edge,
    // so out_valid appears one cycle after the final read returns.
    assign complete   = pend && (fill_cnt == LANES_M1);
    assign flush_take = (state == FILL) && flush && (inflight != '0) && !complete;
    assign flush_done = (state == FILL) && flush_pend && !pend;
    assign handshake  = (state == HOLD) && out_ready;

    always_comb begin
        flush_keep = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            flush_keep[i] = (i < 32'(fill_cnt));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // armed holds off reads until the first clock edge after reset release.
    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        case (state)
            FILL: begin
                fifo_rd_en = armed && !fifo_empty && !flush_pend && (inflight < LANES_C);
                if (complete || flush_done) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = FILL;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed      <= 1'b0;
            pend       <= 1'b0;
            flush_pend <= 1'b0;
            fill_cnt   <= '0;
            out_data   <= '0;
            out_keep   <= '0;
            out_valid  <= 1'b0;
            word_cnt   <= '0;
        end else begin
            armed <= 1'b1;
            pend  <= fifo_rd_en;
            if (pend) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    if (32'(fill_cnt) == i) begin
                        out_data[i*DATA_W +: DATA_W] <= fifo_rdata;
                    end
                end
                fill_cnt <= fill_cnt + CNT_W'(1);
            end
            if (complete) begin
                out_keep   <= '1;
                out_valid  <= 1'b1;
                flush_pend <= 1'b0;
            end else if (flush_done) begin
                out_keep   <= flush_keep;
                out_valid  <= 1'b1;
                flush_pend <= 1'b0;
            end else if (flush_take) begin
                flush_pend <= 1'b1;
            end
            if (handshake) begin
                fill_cnt  <= '0;
                out_data  <= '0;
                out_keep  <= '0;
                out_valid <= 1'b0;
                word_cnt  <= word_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: full word, flushes, backpressure,
// reset mid-fill and word counter wrap, against hand-computed values.
module tb_fifo_word_packer;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned LANES  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata = '0;
    logic        fifo_rd_en;
    logic        flush;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] word_cnt;

    logic [7:0]  mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    int          total = 0;
    int          bad   = 0;
    int          vcyc;
    logic [31:0] rd_mask;

    fifo_word_packer #(.DATA_W(DATA_W), .LANES(LANES)) dut (
        .clk       (clk),
        .reset     (reset),
        .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata),
        .fifo_rd_en(fifo_rd_en),
        .flush     (flush),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    // Upstream FIFO model: read data valid one cycle after the strobe.
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_rdata <= mem[rd_ptr[7:0]];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Steps negedge by negedge until out_valid; logs read cycles as a bitmask.
    task automatic run_until_valid(input int max_cyc);
        rd_mask = '0;
        vcyc    = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            #1;
            if (fifo_rd_en) rd_mask[i] = 1'b1;
            if (out_valid) begin
                vcyc = i;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state, with data already waiting upstream
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        #1;
        check("rst_rd_en",    fifo_rd_en, 0);
        check("rst_valid",    out_valid,  0);
        check("rst_data",     out_data,   0);
        check("rst_keep",     out_keep,   0);
        check("rst_word_cnt", word_cnt,   0);

        @(negedge clk);
        out_ready = 1'b1;
        reset     = 1'b1;
        #1 check("rd_en_before_edge", fifo_rd_en, 0);

        // Full word
        run_until_valid(20);
        check("t1_read_cycles", rd_mask, 32'h0000_000F);
        check("t1_valid_cycle", vcyc, 5);
        check("t1_data",        out_data, 32'h4433_2211);
        check("t1_keep",        out_keep, 4'hF);
        @(negedge clk); #1;
        check("t1_word_cnt",    word_cnt, 1);
        check("t1_valid_clr",   out_valid, 0);
        check("t1_data_clr",    out_data, 0);

        // Partial flush while the second read is pending
        rd_mask = '0;
        push(8'hAA); push(8'hBB);
        #1 rd_mask[0] = fifo_rd_en;
        @(negedge clk); #1 rd_mask[1] = fifo_rd_en;
        @(negedge clk); flush = 1'b1; #1 rd_mask[2] = fifo_rd_en;
        @(negedge clk); flush = 1'b0; push(8'hCC); #1 rd_mask[3] = fifo_rd_en;
        check("t2_read_cycles", rd_mask, 32'h0000_0003);
        run_until_valid(10);
        check("t2_valid_cycle", vcyc, 0);
        check("t2_data",        out_data, 32'h0000_BBAA);
        check("t2_keep",        out_keep, 4'h3);
        @(negedge clk); #1;
        check("t2_word_cnt",    word_cnt, 2);
        check("t2_rd_next",     fifo_rd_en, 1);
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        run_until_valid(10);
        check("t2b_valid_cycle", vcyc, 0);
        check("t2b_data",        out_data, 32'h0000_00CC);
        check("t2b_keep",        out_keep, 4'h1);
        @(negedge clk); #1;
        check("t2b_word_cnt",    word_cnt, 3);
        check("t2b_valid_clr",   out_valid, 0);
        out_ready = 1'b0;

        // Backpressure with more data queued upstream
        push(8'h55); push(8'h66); push(8'h77); push(8'h88);
        run_until_valid(20);
        check("t3_valid_cycle", vcyc, 4);
        push(8'hE1); push(8'hE2); push(8'hE3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            check("t3_hold_data",  out_data, 32'h8877_6655);
            check("t3_hold_valid", out_valid, 1);
            check("t3_hold_rd_en", fifo_rd_en, 0);
        end
        out_ready = 1'b1;
        @(negedge clk); #1;
        check("t3_word_cnt",  word_cnt, 4);
        check("t3_valid_clr", out_valid, 0);
        check("t3_rd_resume", fifo_rd_en, 1);

        // Reset with two lanes captured and a third read in flight
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t4_rst_data",     out_data, 0);
        check("t4_rst_keep",     out_keep, 0);
        check("t4_rst_valid",    out_valid, 0);
        check("t4_rst_word_cnt", word_cnt, 0);
        check("t4_rst_rd_en",    fifo_rd_en, 0);
        @(negedge clk);
        reset = 1'b1;

        // Idle flush is ignored
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check("t5_idle_valid", out_valid, 0);
        end
        check("t5_idle_word_cnt", word_cnt, 0);

        // Fresh word after reset; flush coincides with the final capture and with HOLD
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk); #1;
        check("t6_valid", out_valid, 1);
        check("t6_data",  out_data, 32'h0403_0201);
        check("t6_keep",  out_keep, 4'hF);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("t6_word_cnt",  word_cnt, 1);
        check("t6_valid_clr", out_valid, 0);
        repeat (3) @(negedge clk);
        #1 check("t6_no_extra_word", out_valid, 0);

        // Word counter wrap
        force dut.word_cnt = 16'hFFFF;
        #1;
        release dut.word_cnt;
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        run_until_valid(20);
        check("t7_valid", out_valid, 1);
        check("t7_data",  out_data, 32'hA4A3_A2A1);
        @(negedge clk); #1;
        check("t7_word_cnt_wrap", word_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
